// File: rtl/syscon_rst_seq.sv
// syscon_rst_seq: wb_clk pass-through plus staggered per-domain Wishbone resets.
// Optional watchdog enabled by defining SYSCON_WDT_EN.
module syscon_rst_seq #(
    parameter int unsigned NUM_DOMAINS    = 4,
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned STRETCH_CYCLES = 16,
    parameter int unsigned STAGGER_CYCLES = 8,
    parameter int unsigned CNT_WIDTH      = 8
`ifdef SYSCON_WDT_EN
    ,
    parameter int unsigned WDT_CYCLES     = 1024
`endif
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   soft_rst_req,
    input  logic [NUM_DOMAINS-1:0] domain_hold,
`ifdef SYSCON_WDT_EN
    input  logic                   wdt_kick,
    output logic                   wdt_fired,
`endif
    output logic                   wb_clk,
    output logic [NUM_DOMAINS-1:0] wb_rst,
    output logic                   ready,
    output logic [1:0]             state
);

    localparam int unsigned IW = $clog2(NUM_DOMAINS + 1);

    typedef enum logic [1:0] {
        ST_ASSERT  = 2'd0,
        ST_STRETCH = 2'd1,
        ST_RELEASE = 2'd2,
        ST_RUN     = 2'd3
    } state_e;

    state_e                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic [NUM_DOMAINS-1:0] wb_rst_q, wb_rst_d;
    logic                   ready_q, ready_d;
    logic                   rs_d;
    logic                   soft_go;
    logic                   hold_cur;
    logic                   due_stretch;
    logic                   due_stagger;
    logic                   idx_last;
    logic                   idx_pending;

    assign wb_clk = clk;
    assign wb_rst = wb_rst_q;
    assign ready  = ready_q;
    assign state  = state_q;

    // Synchronised output value taken on this edge; ASSERT exits on its rise.
    assign rs_d        = sync_q[SYNC_STAGES-2];
    assign due_stretch = (cnt_q == CNT_WIDTH'(STRETCH_CYCLES - 1));
    assign due_stagger = (cnt_q == CNT_WIDTH'(STAGGER_CYCLES - 1));
    assign idx_last    = (idx_q == IW'(NUM_DOMAINS - 1));
    assign idx_pending = (idx_q < IW'(NUM_DOMAINS));

`ifdef SYSCON_WDT_EN
    localparam int unsigned WW = $clog2(WDT_CYCLES + 1);

    logic [WW-1:0] wdt_cnt_q, wdt_cnt_d;
    logic          wdt_fired_q;
    logic          wdt_hit;

    assign wdt_hit   = (state_q == ST_RUN) && !wdt_kick &&
                       (wdt_cnt_q == WW'(WDT_CYCLES - 1));
    assign soft_go   = soft_rst_req | wdt_hit;
    assign wdt_fired = wdt_fired_q;

    // Watchdog count runs only in RUN; kick or leaving RUN clears it.
    always_comb begin
        wdt_cnt_d = '0;
        if (state_q == ST_RUN && !soft_go && !wdt_kick) begin
            wdt_cnt_d = wdt_cnt_q + WW'(1);
        end
    end

    // Watchdog counter and sticky fired flag, cleared only by rst.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wdt_cnt_q   <= '0;
            wdt_fired_q <= 1'b0;
        end else begin
            wdt_cnt_q <= wdt_cnt_d;
            if (wdt_hit) begin
                wdt_fired_q <= 1'b1;
            end
        end
    end
`else
    assign soft_go = soft_rst_req;
`endif

    // Hold bit of the domain currently due for release.
    always_comb begin
        hold_cur = 1'b0;
        for (int i = 0; i < NUM_DOMAINS; i++) begin
            if (idx_q == IW'(i)) begin
                hold_cur = domain_hold[i];
            end
        end
    end

    // Reset-release synchroniser, cleared asynchronously.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_ASSERT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; soft reset overrides every sequencer step.
    always_comb begin
        state_d = state_q;
        if (soft_go) begin
            state_d = ST_ASSERT;
        end else begin
            unique case (state_q)
                ST_ASSERT: begin
                    if (rs_d) state_d = ST_STRETCH;
                end
                ST_STRETCH: begin
                    if (due_stretch && !domain_hold[0]) state_d = ST_RELEASE;
                end
                ST_RELEASE: begin
                    if (!idx_pending) begin
                        state_d = ST_RUN;
                    end else if (due_stagger && !hold_cur && idx_last) begin
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: state_d = ST_RUN;
                default: state_d = ST_ASSERT;
            endcase
        end
    end

    // Next values of counter, release index, resets and ready flag.
    always_comb begin
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        wb_rst_d = wb_rst_q;
        ready_d  = 1'b0;
        if (soft_go) begin
            cnt_d    = '0;
            idx_d    = '0;
            wb_rst_d = '1;
        end else begin
            unique case (state_q)
                ST_ASSERT: begin
                    cnt_d    = '0;
                    idx_d    = '0;
                    wb_rst_d = '1;
                end
                ST_STRETCH: begin
                    if (!due_stretch) begin
                        cnt_d = cnt_q + CNT_WIDTH'(1);
                    end else if (!domain_hold[0]) begin
                        wb_rst_d[0] = 1'b0;
                        cnt_d       = '0;
                        idx_d       = IW'(1);
                    end
                end
                ST_RELEASE: begin
                    for (int i = 0; i < NUM_DOMAINS; i++) begin
                        if (IW'(i) < idx_q) wb_rst_d[i] = domain_hold[i];
                    end
                    if (idx_pending) begin
                        if (!due_stagger) begin
                            cnt_d = cnt_q + CNT_WIDTH'(1);
                        end else if (!hold_cur) begin
                            for (int i = 0; i < NUM_DOMAINS; i++) begin
                                if (IW'(i) == idx_q) wb_rst_d[i] = 1'b0;
                            end
                            cnt_d = '0;
                            idx_d = idx_q + IW'(1);
                        end
                    end
                end
                ST_RUN: begin
                    wb_rst_d = domain_hold;
                    ready_d  = ~|domain_hold;
                end
                default: wb_rst_d = '1;
            endcase
        end
    end

    // Datapath registers; all resets asserted asynchronously.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q    <= '0;
            idx_q    <= '0;
            wb_rst_q <= '1;
            ready_q  <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            wb_rst_q <= wb_rst_d;
            ready_q  <= ready_d;
        end
    end

endmodule
